// File: rtl/dzcpu_trace_buffer.sv
// Timestamped trace FIFO for DZCPU retire events and MMU writes.
// Records overflow markers and can freeze capture when a chosen PC retires.
module dzcpu_trace_buffer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TS_WIDTH   = 14
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCaptureEn,
    input  logic        iClear,
    input  logic        iRetire,
    input  logic [15:0] iPc,
    input  logic [7:0]  iA,
    input  logic [7:0]  iFlags,
    input  logic        iMmuWe,
    input  logic [15:0] iMmuAddr,
    input  logic [7:0]  iMmuData,
    input  logic        iStopEn,
    input  logic [15:0] iStopPc,
    input  logic        iRdEn,
    output logic [47:0] oRdData,
    output logic        oRdValid,
    output logic        oEmpty,
    output logic        oFull,
    output logic [7:0]  oDropCount,
    output logic        oStopHit
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [47:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [7:0]            drop_q, drop_d;
    logic                  marker_q, marker_d;
    logic                  pend_q, pend_d;
    logic [47:0]           pend_rec_q, pend_rec_d;
    logic                  stop_arm_q, stop_arm_d;
    logic [47:0]           stop_rec_q, stop_rec_d;
    logic                  stop_hit_q, stop_hit_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [47:0]           rd_data_q;

    logic        full, empty, cap, stop_match, ret_lost, wr_en, rd_fire;
    logic [1:0]  drops;
    logic [8:0]  drop_sum;
    logic [47:0] wr_data, ret_rec, mmu_rec, marker_rec;

    assign full       = (occ_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty      = (occ_q == '0);
    assign cap        = iCaptureEn && !stop_hit_q;
    assign stop_match = iRetire && iStopEn && (iPc == iStopPc);
    assign ret_rec    = {2'b01, ts_q, iPc, iA, iFlags};
    assign mmu_rec    = {2'b10, ts_q, iMmuAddr, iMmuData, 8'h00};
    assign marker_rec = {2'b00, ts_q, 24'h000000, drop_q};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        ts_d       = ts_q + TS_WIDTH'(1);
        drop_d     = drop_q;
        marker_d   = marker_q;
        pend_d     = pend_q;
        pend_rec_d = pend_rec_q;
        stop_arm_d = stop_arm_q;
        stop_rec_d = stop_rec_q;
        stop_hit_d = stop_hit_q;
        wr_en      = 1'b0;
        wr_data    = '0;
        drops      = 2'd0;
        ret_lost   = 1'b0;
        drop_sum   = '0;

        if (cap) begin
            if (stop_match && !stop_arm_q) begin
                stop_arm_d = 1'b1;
                stop_rec_d = {2'b11, ts_q, iPc, 16'h0000};
            end
            // One slot per cycle; whatever loses the slot is held or dropped.
            if (full) begin
                drops = {1'b0, iMmuWe} + {1'b0, iRetire};
            end else if (marker_q && (iMmuWe || iRetire || pend_q || stop_arm_q)) begin
                wr_en    = 1'b1;
                wr_data  = marker_rec;
                marker_d = 1'b0;
                if (iMmuWe) drops = drops + 2'd1;
                ret_lost = iRetire;
            end else if (iMmuWe) begin
                wr_en    = 1'b1;
                wr_data  = mmu_rec;
                ret_lost = iRetire;
            end else if (pend_q) begin
                wr_en    = 1'b1;
                wr_data  = pend_rec_q;
                pend_d   = 1'b0;
                ret_lost = iRetire;
            end else if (stop_arm_q) begin
                wr_en      = 1'b1;
                wr_data    = stop_rec_q;
                stop_arm_d = 1'b0;
                stop_hit_d = 1'b1;
                ret_lost   = iRetire;
            end else if (iRetire) begin
                wr_en   = 1'b1;
                wr_data = ret_rec;
            end
            if (ret_lost) begin
                if (pend_q) begin
                    drops = drops + 2'd1;
                end else begin
                    pend_d     = 1'b1;
                    pend_rec_d = ret_rec;
                end
            end
        end

        drop_sum = {1'b0, drop_q} + {7'b0, drops};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (drops != 2'd0) marker_d = 1'b1;

        rd_fire    = iRdEn && !empty && !iClear;
        rd_valid_d = rd_fire;
        if (rd_fire) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        if (wr_en)   wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        occ_d = occ_q + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(rd_fire);

        // Flush overrides every same-cycle event; rd_data_q keeps its value.
        if (iClear) begin
            wr_en      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            ts_d       = '0;
            drop_d     = '0;
            marker_d   = 1'b0;
            pend_d     = 1'b0;
            stop_arm_d = 1'b0;
            stop_hit_d = 1'b0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            ts_q       <= '0;
            drop_q     <= '0;
            marker_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_rec_q <= '0;
            stop_arm_q <= 1'b0;
            stop_rec_q <= '0;
            stop_hit_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            ts_q       <= ts_d;
            drop_q     <= drop_d;
            marker_q   <= marker_d;
            pend_q     <= pend_d;
            pend_rec_q <= pend_rec_d;
            stop_arm_q <= stop_arm_d;
            stop_rec_q <= stop_rec_d;
            stop_hit_q <= stop_hit_d;
            rd_valid_q <= rd_valid_d;
            if (rd_fire) rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Head and tail only share an address when empty or full, so no read/write hazard.
    always_ff @(posedge iClock) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign oRdData    = rd_data_q;
    assign oRdValid   = rd_valid_q;
    assign oEmpty     = empty;
    assign oFull      = full;
    assign oDropCount = drop_q;
    assign oStopHit   = stop_hit_q;
endmodule

// File: tb/tb_dzcpu_trace_buffer.sv
// Randomized and directed bench for dzcpu_trace_buffer against a queue-based reference model.
module tb_dzcpu_trace_buffer;
    localparam int DEPTH = 64;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iCaptureEn, iClear, iRetire, iMmuWe, iStopEn, iRdEn;
    logic [15:0] iPc, iMmuAddr, iStopPc;
    logic [7:0]  iA, iFlags, iMmuData;
    logic [47:0] oRdData;
    logic        oRdValid, oEmpty, oFull, oStopHit;
    logic [7:0]  oDropCount;

    always #5 iClock = ~iClock;

    dzcpu_trace_buffer dut (
        .iClock(iClock), .iReset(iReset), .iCaptureEn(iCaptureEn), .iClear(iClear),
        .iRetire(iRetire), .iPc(iPc), .iA(iA), .iFlags(iFlags),
        .iMmuWe(iMmuWe), .iMmuAddr(iMmuAddr), .iMmuData(iMmuData),
        .iStopEn(iStopEn), .iStopPc(iStopPc), .iRdEn(iRdEn),
        .oRdData(oRdData), .oRdValid(oRdValid), .oEmpty(oEmpty), .oFull(oFull),
        .oDropCount(oDropCount), .oStopHit(oStopHit)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: trace stream as queues, one arbitration decision per cycle.
    logic [47:0] m_fifo[$];
    logic [47:0] m_pend[$];
    logic [47:0] m_stop[$];
    int          m_drops;
    bit          m_marker, m_hit, m_rdvalid;
    logic [47:0] m_rddata;
    logic [13:0] m_ts;

    task automatic model_reset();
        m_fifo.delete(); m_pend.delete(); m_stop.delete();
        m_drops = 0; m_marker = 0; m_hit = 0; m_rdvalid = 0; m_rddata = '0; m_ts = '0;
    endtask

    task automatic model_step();
        logic [47:0] cand[$];
        int          kind[$];
        bit          full, pend_pre, stop_pre;
        int          nd;
        logic [47:0] ret_rec;
        if (iClear) begin
            m_fifo.delete(); m_pend.delete(); m_stop.delete();
            m_drops = 0; m_marker = 0; m_hit = 0; m_rdvalid = 0; m_ts = '0;
            return;
        end
        full     = (m_fifo.size() == DEPTH);
        pend_pre = (m_pend.size() != 0);
        stop_pre = (m_stop.size() != 0);
        m_rdvalid = 0;
        if (iRdEn && m_fifo.size() != 0) begin
            m_rddata  = m_fifo.pop_front();
            m_rdvalid = 1;
        end
        if (iCaptureEn && !m_hit) begin
            ret_rec = {2'b01, m_ts, iPc, iA, iFlags};
            nd = 0;
            if (full) begin
                nd = int'(iMmuWe) + int'(iRetire);
            end else begin
                if (iMmuWe)   begin cand.push_back({2'b10, m_ts, iMmuAddr, iMmuData, 8'h00}); kind.push_back(1); end
                if (pend_pre) begin cand.push_back(m_pend[0]); kind.push_back(2); end
                if (stop_pre) begin cand.push_back(m_stop[0]); kind.push_back(3); end
                if (iRetire)  begin cand.push_back(ret_rec); kind.push_back(4); end
                if (m_marker && cand.size() != 0) begin
                    cand.push_front({2'b00, m_ts, 24'h0, 8'(m_drops)});
                    kind.push_front(0);
                end
                if (cand.size() != 0) begin
                    m_fifo.push_back(cand[0]);
                    case (kind[0])
                        0: m_marker = 0;
                        2: void'(m_pend.pop_front());
                        3: begin m_stop.delete(); m_hit = 1; end
                        default: ;
                    endcase
                end
                for (int i = 1; i < cand.size(); i++) begin
                    if (kind[i] == 1) nd++;
                    if (kind[i] == 4) begin
                        if (pend_pre) nd++;
                        else m_pend.push_back(ret_rec);
                    end
                end
            end
            if (iRetire && iStopEn && iPc == iStopPc && !stop_pre)
                m_stop.push_back({2'b11, m_ts, iPc, 16'h0000});
            m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
            if (nd != 0) m_marker = 1;
        end
        m_ts = m_ts + 14'd1;
    endtask

    task automatic compare();
        chk("empty",    48'(oEmpty),     48'(m_fifo.size() == 0));
        chk("full",     48'(oFull),      48'(m_fifo.size() == DEPTH));
        chk("dropcnt",  48'(oDropCount), 48'(m_drops));
        chk("stophit",  48'(oStopHit),   48'(m_hit));
        chk("rdvalid",  48'(oRdValid),   48'(m_rdvalid));
        chk("rddata",   oRdData,         m_rddata);
    endtask

    task automatic cycle();
        model_step();
        @(posedge iClock);
        #1;
        compare();
        if (oRdValid)
            $display("[TB] pop tag=%0d ts=%04h payload=%08h", oRdData[47:46], oRdData[45:32], oRdData[31:0]);
    endtask

    task automatic set_idle();
        iCaptureEn = 1'b1; iClear = 1'b0; iRetire = 1'b0; iMmuWe = 1'b0; iRdEn = 1'b0;
        iStopEn = 1'b0; iPc = '0; iA = '0; iFlags = '0; iMmuAddr = '0; iMmuData = '0; iStopPc = '0;
    endtask

    task automatic do_clear();
        set_idle(); iClear = 1'b1; cycle(); iClear = 1'b0;
    endtask

    task automatic mmu_burst(input int n);
        for (int i = 0; i < n; i++) begin
            iMmuWe = 1'b1; iMmuAddr = 16'($urandom); iMmuData = 8'($urandom);
            cycle();
        end
        iMmuWe = 1'b0;
    endtask

    initial begin
        int          pr, pm, pd;
        logic [7:0]  saved_drop;
        logic [47:0] last_pop;
        set_idle();
        #1 iReset = 1'b0;
        #2;
        chk("reset_rddata", oRdData, 48'h0);
        chk("reset_flags", {44'h0, oRdValid, oEmpty, oFull, oStopHit}, {44'h0, 4'b0100});
        chk("reset_drop", 48'(oDropCount), 48'h0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        model_reset();

        // Single retire presented at ts=5.
        repeat (5) cycle();
        iRetire = 1'b1; iPc = 16'h0150; iA = 8'h01; iFlags = 8'hB0;
        cycle();
        iRetire = 1'b0; iRdEn = 1'b1;
        cycle();
        iRdEn = 1'b0;
        chk("t1_entry", oRdData, 48'h4005_0150_01B0);
        chk("t1_valid", 48'(oRdValid), 48'h1);
        chk("t1_empty", 48'(oEmpty), 48'h1);
        cycle();
        chk("t1_valid_pulse", 48'(oRdValid), 48'h0);

        // Retire/MMU collision.
        iRetire = 1'b1; iPc = 16'h1234; iA = 8'h56; iFlags = 8'h78;
        iMmuWe = 1'b1; iMmuAddr = 16'hFF40; iMmuData = 8'h91;
        cycle();
        iRetire = 1'b0; iMmuWe = 1'b0;
        cycle();
        iRdEn = 1'b1;
        cycle();
        chk("t2_mmu_first", {14'h0, oRdData[47:46], oRdData[31:0]}, {14'h0, 2'b10, 32'hFF40_9100});
        cycle();
        chk("t2_retire_next", {14'h0, oRdData[47:46], oRdData[31:0]}, {14'h0, 2'b01, 32'h1234_5678});
        iRdEn = 1'b0;
        chk("t2_nodrop", 48'(oDropCount), 48'h0);

        // Overflow and marker.
        mmu_burst(67);
        chk("t3_full", 48'(oFull), 48'h1);
        chk("t3_drop3", 48'(oDropCount), 48'h3);
        iRdEn = 1'b1; cycle(); iRdEn = 1'b0;
        mmu_burst(1);
        chk("t3_drop4", 48'(oDropCount), 48'h4);
        iRdEn = 1'b1;
        repeat (66) begin
            cycle();
            if (oRdValid) last_pop = oRdData;
        end
        iRdEn = 1'b0;
        chk("t3_marker", {14'h0, last_pop[47:46], last_pop[31:0]}, {14'h0, 2'b00, 32'h0000_0003});
        do_clear();

        // Stop-PC freeze.
        iStopEn = 1'b1; iStopPc = 16'h003E;
        iRetire = 1'b1; iPc = 16'h003E; iA = 8'hAA; iFlags = 8'h00;
        cycle();
        iRetire = 1'b0;
        cycle();
        chk("t4_stophit", 48'(oStopHit), 48'h1);
        saved_drop = oDropCount;
        for (int i = 0; i < 10; i++) begin
            iRetire = 1'b1; iPc = 16'($urandom); iMmuWe = 1'b1; iMmuAddr = 16'($urandom);
            cycle();
        end
        iRetire = 1'b0; iMmuWe = 1'b0;
        chk("t4_drop_frozen", 48'(oDropCount), 48'(saved_drop));
        iRdEn = 1'b1;
        cycle();
        chk("t4_retire", {14'h0, oRdData[47:46], oRdData[31:0]}, {14'h0, 2'b01, 32'h003E_AA00});
        cycle();
        chk("t4_stop", {14'h0, oRdData[47:46], oRdData[31:0]}, {14'h0, 2'b11, 32'h003E_0000});
        cycle();
        chk("t4_empty", 48'(oEmpty), 48'h1);
        iStopEn = 1'b0;
        do_clear();

        // Randomized traffic in write-heavy, balanced and read-heavy blocks.
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0:       begin pr = 60; pm = 55; pd = 15; end
                1:       begin pr = 40; pm = 30; pd = 50; end
                default: begin pr = 20; pm = 20; pd = 85; end
            endcase
            do_clear();
            iStopEn = (blk == 4); iStopPc = 16'h0100;
            for (int c = 0; c < 500; c++) begin
                iRetire    = ($urandom_range(99) < pr);
                iPc        = iStopEn ? 16'($urandom_range(16'h0108, 16'h00F8)) : 16'($urandom);
                iA         = 8'($urandom); iFlags = 8'($urandom);
                iMmuWe     = ($urandom_range(99) < pm);
                iMmuAddr   = 16'($urandom); iMmuData = 8'($urandom);
                iRdEn      = ($urandom_range(99) < pd);
                iCaptureEn = ($urandom_range(99) < 92);
                iClear     = ($urandom_range(999) < 3);
                cycle();
            end
        end
        do_clear();

        // Timestamp wrap, then flush with entries queued.
        repeat (16384) cycle();
        mmu_burst(1);
        iRdEn = 1'b1; cycle(); iRdEn = 1'b0;
        chk("t5_ts_wrap", 48'(oRdData[45:32]), 48'h0);
        mmu_burst(10);
        iClear = 1'b1; cycle(); iClear = 1'b0;
        chk("t5_clr_empty", 48'(oEmpty), 48'h1);
        chk("t5_clr_drop", 48'(oDropCount), 48'h0);
        chk("t5_clr_stop", 48'(oStopHit), 48'h0);

        // Asynchronous reset mid-operation.
        mmu_burst(66);
        iRdEn = 1'b1; cycle(); iRdEn = 1'b0;
        #3 iReset = 1'b0;
        #1;
        chk("t6_rddata", oRdData, 48'h0);
        chk("t6_flags", {44'h0, oRdValid, oEmpty, oFull, oStopHit}, {44'h0, 4'b0100});
        chk("t6_drop", 48'(oDropCount), 48'h0);
        model_reset();
        @(posedge iClock); #2;
        iReset = 1'b1;
        repeat (4) cycle();
        mmu_burst(3);
        iRdEn = 1'b1; repeat (4) cycle(); iRdEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
